// File: rtl/spi_flash_writer.sv
// Single-bit SPI mode-0 programmer for the boot flash: continuous-mode exit, WREN, program/erase, then WIP polling.
// Optional poll timeout is compiled in with `define SPI_WRITER_TIMEOUT_EN.
module spi_flash_writer #(
  parameter int CS_GAP   = 4,
  parameter int POLL_MAX = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  cmd,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  status,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    S_IDLE, S_MRST, S_WREN, S_CMD, S_POLL, S_GAP, S_BAD, S_DONE
  } state_t;

  localparam int GW = $clog2(CS_GAP + 1);

  state_t        state, state_nxt, ret_state;
  logic [1:0]    cmd_q;
  logic [23:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [63:0]   sh, ld_data;
  logic [6:0]    bit_cnt, nbits_m1, ld_nbm1;
  logic          phase;
  logic [6:0]    rx;
  logic [7:0]    status_q;
  logic          err_q;
  logic [GW-1:0] gap_cnt;
  logic          tx_active, tx_next, last_bit;
  logic [23:0]   byte_addr;

`ifdef SPI_WRITER_TIMEOUT_EN
  localparam int PW = $clog2(POLL_MAX + 1);
  logic [PW-1:0] poll_cnt;
`endif

  assign byte_addr = {addr_q[21:0], 2'b00};
  assign tx_active = (state == S_MRST) || (state == S_WREN) || (state == S_CMD) || (state == S_POLL);
  assign tx_next   = (state_nxt == S_MRST) || (state_nxt == S_WREN) ||
                     (state_nxt == S_CMD) || (state_nxt == S_POLL);
  assign last_bit  = tx_active && phase && (bit_cnt == nbits_m1);

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    spi_cs_n  = ~tx_active;
    spi_sck   = tx_active & phase;
    spi_mosi  = tx_active & sh[63];
    case (state)
      S_IDLE:                       if (start) state_nxt = (cmd == 2'b11) ? S_BAD : S_MRST;
      S_MRST, S_WREN, S_CMD, S_POLL: if (last_bit) state_nxt = S_GAP;
      S_GAP:                        if (gap_cnt == '0) state_nxt = ret_state;
      S_BAD:                        state_nxt = S_DONE;
      S_DONE:                       state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  // Frame for the transaction about to start, left-aligned so bits leave from sh[63].
  always_comb begin
    ld_data = '0;
    ld_nbm1 = '0;
    case (state_nxt)
      S_MRST: begin ld_data = {8'hFF, 56'h0}; ld_nbm1 = 7'd7; end
      S_WREN: begin ld_data = {8'h06, 56'h0}; ld_nbm1 = 7'd7; end
      S_POLL: begin ld_data = {8'h05, 56'h0}; ld_nbm1 = 7'd15; end
      S_CMD: begin
        case (cmd_q)
          2'b00:   begin ld_data = {8'h02, byte_addr, wdata_q}; ld_nbm1 = 7'd63; end
          2'b01:   begin ld_data = {8'h20, byte_addr, 32'h0};   ld_nbm1 = 7'd31; end
          default: begin ld_data = {8'hC7, 56'h0};              ld_nbm1 = 7'd7;  end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sh        <= '0;
      bit_cnt   <= '0;
      nbits_m1  <= '0;
      phase     <= 1'b0;
      rx        <= '0;
      status_q  <= '0;
      err_q     <= 1'b0;
      gap_cnt   <= '0;
`ifdef SPI_WRITER_TIMEOUT_EN
      poll_cnt  <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        cmd_q   <= cmd;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= 1'b0;
`ifdef SPI_WRITER_TIMEOUT_EN
        poll_cnt <= '0;
`endif
      end
      if (tx_next && state_nxt != state) begin
        sh       <= ld_data;
        nbits_m1 <= ld_nbm1;
        bit_cnt  <= '0;
        phase    <= 1'b0;
      end else if (tx_active) begin
        phase <= ~phase;
        if (phase) begin
          rx <= {rx[5:0], spi_miso};
          if (!last_bit) begin
            sh      <= {sh[62:0], 1'b0};
            bit_cnt <= bit_cnt + 7'd1;
          end
        end
      end
      if (state_nxt == S_GAP && state != S_GAP) gap_cnt <= GW'(CS_GAP);
      else if (state == S_GAP)                  gap_cnt <= gap_cnt - 1'b1;
      if (state == S_BAD) err_q <= 1'b1;
      if (last_bit) begin
        case (state)
          S_MRST: ret_state <= S_WREN;
          S_WREN: ret_state <= S_CMD;
          S_CMD:  ret_state <= S_POLL;
          default: begin
            // The final bit read is WIP; it arrives on miso in this very cycle.
            status_q  <= {rx, spi_miso};
            ret_state <= spi_miso ? S_POLL : S_DONE;
`ifdef SPI_WRITER_TIMEOUT_EN
            poll_cnt <= poll_cnt + 1'b1;
            if (spi_miso && poll_cnt == PW'(POLL_MAX - 1)) begin
              ret_state <= S_DONE;
              err_q     <= 1'b1;
            end
`endif
          end
        endcase
      end
    end
  end

  assign error  = err_q;
  assign status = status_q;

endmodule

// File: tb/tb_spi_flash_writer.sv
// Table-driven bench for spi_flash_writer with a behavioural SPI flash that logs every transaction
// and answers RDSR with a scripted WIP sequence.
module tb_spi_flash_writer;
  localparam int CS_GAP = 4;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [23:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, error, spi_cs_n, spi_sck, spi_mosi, spi_miso;
  logic [7:0]  status;

  int checks = 0, failures = 0;

  spi_flash_writer #(.CS_GAP(CS_GAP), .POLL_MAX(4)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .error(error), .status(status),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  // Flash model: bytes captured on sck rise, RDSR answers 03 (WEL|WIP) for the first n_busy polls.
  logic        clr_log = 1'b0;
  int          n_busy = 0;
  int          bitcnt = 0, tx_cnt = 0, poll_idx = 0, gap_run = 0, min_gap = 1000;
  logic [63:0] cur = '0;
  logic [7:0]  first_byte = '0, stat_byte;
  logic        prev_sck = 1'b0, prev_cs = 1'b1;
  logic [63:0] tx_data [32];
  int          tx_bits [32];

  assign stat_byte = (poll_idx < n_busy) ? 8'h03 : 8'h00;
  assign spi_miso  = (!spi_cs_n && first_byte == 8'h05 && bitcnt >= 8 && bitcnt < 16) ?
                     stat_byte[15 - bitcnt] : 1'b0;

  always @(posedge clk) begin
    prev_sck <= spi_sck;
    prev_cs  <= spi_cs_n;
    if (clr_log) begin
      tx_cnt <= 0; poll_idx <= 0; min_gap <= 1000; bitcnt <= 0; cur <= '0; first_byte <= '0;
    end else begin
      if (!spi_cs_n && spi_sck && !prev_sck) begin
        cur    <= {cur[62:0], spi_mosi};
        if (bitcnt == 7) first_byte <= {cur[6:0], spi_mosi};
        bitcnt <= bitcnt + 1;
      end
      if (spi_cs_n && !prev_cs) begin
        if (tx_cnt < 32) begin tx_data[tx_cnt] <= cur; tx_bits[tx_cnt] <= bitcnt; end
        tx_cnt <= tx_cnt + 1;
        if (first_byte == 8'h05) poll_idx <= poll_idx + 1;
        bitcnt <= 0; cur <= '0; first_byte <= '0; gap_run <= 1;
      end else if (spi_cs_n) gap_run <= gap_run + 1;
      if (!spi_cs_n && prev_cs && tx_cnt > 0 && gap_run < min_gap) min_gap <= gap_run;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one operation; lat is the done cycle index counting the start cycle as 0.
  task automatic run_op(input logic [1:0] c, input logic [23:0] a, input logic [31:0] w,
                        input int nb, input bit poke, output int lat, output int dones,
                        output logic busy1, output logic got_err, output logic [7:0] got_stat,
                        output logic busy_done, output bit timed_out);
    bit seen = 0;
    lat = 0; dones = 0; got_err = 1'b0; got_stat = '0; busy_done = 1'b1;
    @(negedge clk); clr_log = 1'b1; n_busy = nb;
    @(negedge clk); clr_log = 1'b0;
    cmd = c; addr = a; wdata = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cmd = ~c; addr = ~a; wdata = ~w;
    busy1 = busy;
    for (int i = 1; i < 3000; i++) begin
      @(posedge clk); #1;
      if (poke && i == 180) begin start = 1'b1; cmd = 2'b10; end
      else start = 1'b0;
      if (done) begin
        dones++;
        if (!seen) begin
          seen = 1; lat = i + 1; got_err = error; got_stat = status; busy_done = busy;
        end
      end
      if (seen && i >= lat + 4) break;
    end
    timed_out = !seen;
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [23:0] addr;
    logic [31:0] wdata;
    int          nbusy;
    int          exp_ntx;
    logic [63:0] exp_cmd;
    int          exp_bits;
    logic        exp_err;
    logic [7:0]  exp_status;
    int          exp_lat;
  } vec_t;

  vec_t vt [5];
  int          lat, dones;
  logic        busy1, got_err, busy_done;
  logic [7:0]  got_stat;
  bit          tmo;
  // one-poll program: every bit is 2 cycles, four gaps of CS_GAP+1, done in the cycle after the last gap
  localparam int PROG1 = (8 + 8 + 64 + 16) * 2 + 4 * (CS_GAP + 1) + 1;
  localparam int POLLX = 32 + CS_GAP + 1;

  initial begin
    vt[0] = '{2'b00, 24'h000010, 32'h12345678, 2, 6, 64'h02000040_12345678, 64, 1'b0, 8'h00, PROG1 + 2 * POLLX};
    vt[1] = '{2'b01, 24'h000400, 32'h0,        0, 4, 64'h20001000,          32, 1'b0, 8'h00, PROG1 - 64};
    vt[2] = '{2'b10, 24'h0,      32'h0,        1, 5, 64'hC7,                8,  1'b0, 8'h00, PROG1 - 112 + POLLX};
    vt[3] = '{2'b00, 24'hC00001, 32'hDEADBEEF, 0, 4, 64'h02000004_DEADBEEF, 64, 1'b0, 8'h00, PROG1};
    vt[4] = '{2'b11, 24'h000010, 32'h0,        0, 0, 64'h0,                 0,  1'b1, 8'h00, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);   chk("rst_error", error, 0);
    chk("rst_status", status, 0); chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sck", spi_sck, 0); chk("rst_mosi", spi_mosi, 0);
    @(negedge clk); reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_op(vt[v].cmd, vt[v].addr, vt[v].wdata, vt[v].nbusy, 0, lat, dones, busy1, got_err, got_stat, busy_done, tmo);
      chk($sformatf("v%0d_timeout", v), tmo, 0);
      chk($sformatf("v%0d_latency", v), lat, vt[v].exp_lat);
      chk($sformatf("v%0d_dones", v), dones, 1);
      chk($sformatf("v%0d_busy1", v), busy1, 1);
      chk($sformatf("v%0d_busy_at_done", v), busy_done, 0);
      chk($sformatf("v%0d_error", v), got_err, vt[v].exp_err);
      chk($sformatf("v%0d_status", v), got_stat, vt[v].exp_status);
      chk($sformatf("v%0d_ntx", v), tx_cnt, vt[v].exp_ntx);
      chk($sformatf("v%0d_busy_after", v), busy, 0);
      if (vt[v].exp_ntx >= 4 && tx_cnt == vt[v].exp_ntx) begin
        chk($sformatf("v%0d_mrst", v), {tx_data[0][7:0], 8'(tx_bits[0])}, {8'hFF, 8'd8});
        chk($sformatf("v%0d_wren", v), {tx_data[1][7:0], 8'(tx_bits[1])}, {8'h06, 8'd8});
        chk($sformatf("v%0d_cmd_data", v), tx_data[2], vt[v].exp_cmd);
        chk($sformatf("v%0d_cmd_sck_rises", v), tx_bits[2], vt[v].exp_bits);
        chk($sformatf("v%0d_last_poll", v), {tx_data[tx_cnt-1][15:0], 8'(tx_bits[tx_cnt-1])},
            {8'h05, vt[v].exp_status, 8'd16});
        chk($sformatf("v%0d_gap_ok", v), min_gap >= CS_GAP, 1);
      end
    end

    // start pulsed during the first poll with a different command must be ignored
    run_op(2'b00, 24'h000010, 32'h12345678, 2, 1, lat, dones, busy1, got_err, got_stat, busy_done, tmo);
    chk("poke_dones", dones, 1);
    chk("poke_latency", lat, PROG1 + 2 * POLLX);
    chk("poke_ntx", tx_cnt, 6);
    if (tx_cnt == 6) chk("poke_cmd_data", tx_data[2], 64'h02000040_12345678);

    // reset in the middle of the program command
    @(negedge clk); clr_log = 1'b1; n_busy = 0;
    @(negedge clk); clr_log = 1'b0;
    cmd = 2'b00; addr = 24'h000010; wdata = 32'h12345678; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    tmo = 1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (tx_cnt == 2 && bitcnt == 20) begin tmo = 0; break; end
    end
    chk("rstmid_reach_bit20", tmo, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_cs_n", spi_cs_n, 1); chk("rstmid_sck", spi_sck, 0);
    chk("rstmid_busy", busy, 0);     chk("rstmid_done", done, 0);
    @(negedge clk); reset = 1'b0;
    dones = 0;
    repeat (10) begin @(posedge clk); #1; if (done) dones++; end
    chk("rstmid_no_done", dones, 0);
    run_op(2'b00, 24'h000010, 32'h12345678, 0, 0, lat, dones, busy1, got_err, got_stat, busy_done, tmo);
    chk("rstmid_rerun_latency", lat, PROG1);
    chk("rstmid_rerun_ntx", tx_cnt, 4);
    if (tx_cnt == 4) chk("rstmid_rerun_cmd", tx_data[2], 64'h02000040_12345678);

`ifdef SPI_WRITER_TIMEOUT_EN
    run_op(2'b00, 24'h000010, 32'h12345678, 1000, 0, lat, dones, busy1, got_err, got_stat, busy_done, tmo);
    chk("tmo_done_seen", tmo, 0);
    chk("tmo_polls", tx_cnt - 3, 4);
    chk("tmo_error", got_err, 1);
    chk("tmo_status", got_stat, 8'h03);
    chk("tmo_latency", lat, PROG1 + 3 * POLLX);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
